// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM state encoding,
// default sizes and the carry-in selection rule.
package alu_pkg;

    localparam int WIDTH = 8;
    localparam int NREGS = 4;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_GT   = 3'b101;
    localparam logic [2:0] OP_SHLA = 3'b110;
    localparam logic [2:0] OP_SHLB = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

    // SUB defaults ci to 1 because the ALU computes A + ~B + ci
    function automatic logic ci_select(input logic [2:0] opcode,
                                       input logic       use_c,
                                       input logic       flag_c);
        logic ci;
        case (opcode)
            OP_ADD:  ci = use_c ? flag_c : 1'b0;
            OP_SUB:  ci = use_c ? flag_c : 1'b1;
            default: ci = 1'b0;
        endcase
        return ci;
    endfunction

    function automatic logic is_carry_op(input logic [2:0] opcode);
        logic carry_op;
        case (opcode)
            OP_ADD:  carry_op = 1'b1;
            OP_SUB:  carry_op = 1'b1;
            default: carry_op = 1'b0;
        endcase
        return carry_op;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_regfile.sv
// Small register file for the sequencer: async-cleared storage, one write port
// where an ALU writeback beats an external load to the same entry.
module alu_regfile #(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 4,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [AW-1:0]    rs1_addr,
    output logic [WIDTH-1:0] rs1_data,
    input  logic [AW-1:0]    rs2_addr,
    output logic [WIDTH-1:0] rs2_data,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] mem_r [NREGS];

    // Storage update: writeback has priority, a colliding load is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wb_en && (wb_addr == AW'(i))) begin
                    mem_r[i] <= wb_data;
                end else if (ld_en && (ld_addr == AW'(i))) begin
                    mem_r[i] <= ld_data;
                end
            end
        end
    end

    assign rs1_data = mem_r[rs1_addr];
    assign rs2_data = mem_r[rs2_addr];
    assign dbg_data = mem_r[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Register-to-register execution stage in front of the combinational ALU:
// accept one instruction, drive the ALU for one cycle, write result and flags back.
module alu_op_sequencer #(
    parameter  int WIDTH = alu_pkg::WIDTH,
    parameter  int NREGS = alu_pkg::NREGS,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_opcode,
    input  logic             in_use_c,
    input  logic [AW-1:0]    in_rd,
    input  logic [AW-1:0]    in_rs1,
    input  logic [AW-1:0]    in_rs2,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_opcode,
    output logic             alu_ci,
    input  logic [WIDTH-1:0] alu_fin,
    input  logic             alu_co,
    input  logic             alu_cf,
    input  logic             alu_zf,
    output logic             done,
    output logic             flag_c,
    output logic             flag_cf,
    output logic             flag_z
);

    import alu_pkg::*;

    state_e           state_r;
    state_e           state_s;
    logic             accept_s;
    logic             wb_s;
    logic [AW-1:0]    rd_r;
    logic [WIDTH-1:0] rs1_data_s;
    logic [WIDTH-1:0] rs2_data_s;

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_en    (wb_s),
        .wb_addr  (rd_r),
        .wb_data  (alu_fin),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .rs1_addr (in_rs1),
        .rs1_data (rs1_data_s),
        .rs2_addr (in_rs2),
        .rs2_data (rs2_data_s),
        .dbg_addr (rd_addr),
        .dbg_data (rd_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode: accept in IDLE, write back on the EXEC closing edge
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        wb_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_s = 1'b1;
                    state_s  = ST_EXEC;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_EXEC: begin
                wb_s    = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign in_ready = (state_r == ST_IDLE);

    // Operand capture and flag writeback; ALU inputs are the operand registers.
    // use_c is folded into the registered ci at accept, since flag_c cannot
    // change until this instruction's own writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= {WIDTH{1'b0}};
            alu_b      <= {WIDTH{1'b0}};
            alu_opcode <= 3'b000;
            alu_ci     <= 1'b0;
            rd_r       <= {AW{1'b0}};
            done       <= 1'b0;
            flag_c     <= 1'b0;
            flag_cf    <= 1'b0;
            flag_z     <= 1'b0;
        end else begin
            done <= wb_s;
            if (accept_s) begin
                alu_a      <= rs1_data_s;
                alu_b      <= rs2_data_s;
                alu_opcode <= in_opcode;
                alu_ci     <= ci_select(in_opcode, in_use_c, flag_c);
                rd_r       <= in_rd;
            end
            if (wb_s) begin
                flag_cf <= alu_cf;
                flag_z  <= alu_zf;
                if (is_carry_op(alu_opcode)) begin
                    flag_c <= alu_co;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: sequencer plus a behavioural model of the combinational ALU.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_opcode;
    logic       in_use_c;
    logic [1:0] in_rd, in_rs1, in_rs2;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] alu_a, alu_b, alu_fin;
    logic [2:0] alu_opcode;
    logic       alu_ci, alu_co, alu_cf, alu_zf;
    logic       done, flag_c, flag_cf, flag_z;
    logic [8:0] m_sum;

    int vectors     = 0;
    int miscompares = 0;
    int accepts     = 0;
    logic sampled_co;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_use_c(in_use_c), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_ci(alu_ci),
        .alu_fin(alu_fin), .alu_co(alu_co), .alu_cf(alu_cf), .alu_zf(alu_zf),
        .done(done), .flag_c(flag_c), .flag_cf(flag_cf), .flag_z(flag_z)
    );

    // ALU model: ADD/SUB with carry, logic ops, compare, shifts
    always_comb begin
        m_sum   = 9'h000;
        alu_fin = 8'h00;
        alu_co  = 1'b0;
        alu_cf  = 1'b0;
        case (alu_opcode)
            3'b000: begin
                m_sum   = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_ci};
                alu_fin = m_sum[7:0];
                alu_co  = m_sum[8];
                alu_cf  = m_sum[8];
            end
            3'b001: begin
                m_sum   = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'h00, alu_ci};
                alu_fin = m_sum[7:0];
                alu_co  = m_sum[8];
                alu_cf  = m_sum[8];
            end
            3'b010: alu_fin = alu_a & alu_b;
            3'b011: alu_fin = alu_a | alu_b;
            3'b100: alu_fin = alu_a ^ alu_b;
            3'b101: begin
                alu_fin = (alu_a > alu_b) ? 8'h01 : 8'h00;
                alu_cf  = (alu_a > alu_b);
            end
            3'b110: begin
                alu_fin = {alu_a[6:0], 1'b0};
                alu_cf  = alu_a[7];
            end
            default: begin
                alu_fin = {alu_b[6:0], 1'b0};
                alu_cf  = alu_b[7];
            end
        endcase
    end
    assign alu_zf = (alu_fin == 8'h00);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [1:0] a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        check(tag, {8'h00, rd_data}, {8'h00, exp});
    endtask

    // One instruction; optional load placed on the writeback edge
    task automatic issue(input string tag, input logic [2:0] op, input logic use_c,
                         input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2,
                         input logic exp_ci, input logic ld_on, input logic [1:0] la,
                         input logic [7:0] ld);
        in_valid  = 1'b1;
        in_opcode = op;
        in_use_c  = use_c;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        check({tag, "_ready_idle"}, {15'h0, in_ready}, 16'h0001);
        tick();
        in_valid = 1'b0;
        check({tag, "_ready_exec"}, {15'h0, in_ready}, 16'h0000);
        check({tag, "_ci"}, {15'h0, alu_ci}, {15'h0, exp_ci});
        sampled_co = alu_co;
        ld_en   = ld_on;
        ld_addr = la;
        ld_data = ld;
        tick();
        ld_en = 1'b0;
        check({tag, "_done"}, {15'h0, done}, 16'h0001);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_opcode = 3'b000; in_use_c = 1'b0;
        in_rd = 2'd0; in_rs1 = 2'd0; in_rs2 = 2'd0; ld_en = 1'b0; ld_addr = 2'd0;
        ld_data = 8'h00; rd_addr = 2'd0; sampled_co = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_ready", {15'h0, in_ready}, 16'h0001);
        check("rst_done", {15'h0, done}, 16'h0000);
        check("rst_flags", {13'h0, flag_c, flag_cf, flag_z}, 16'h0000);
        check("rst_alu_a", {8'h00, alu_a}, 16'h0000);
        chk_reg("rst_r0", 2'd0, 8'h00);

        // 1: ADD
        load(2'd0, 8'hF6);
        load(2'd1, 8'h95);
        issue("add", 3'b000, 1'b0, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0, 8'h00);
        chk_reg("add_r2", 2'd2, 8'h8B);
        check("add_flags", {13'h0, flag_c, flag_cf, flag_z}, 16'h0006);

        // 2: logic ops keep flag_c, SUB updates it
        issue("and", 3'b010, 1'b0, 2'd3, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0, 8'h00);
        chk_reg("and_r3", 2'd3, 8'h94);
        check("and_flag_c", {15'h0, flag_c}, 16'h0001);
        issue("xor", 3'b100, 1'b0, 2'd3, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0, 8'h00);
        chk_reg("xor_r3", 2'd3, 8'h63);
        issue("sub", 3'b001, 1'b0, 2'd2, 2'd0, 2'd1, 1'b1, 1'b0, 2'd0, 8'h00);
        chk_reg("sub_r2", 2'd2, 8'h61);
        check("sub_flag_c_sampled", {15'h0, flag_c}, {15'h0, sampled_co});
        check("sub_flag_c", {15'h0, flag_c}, 16'h0001);

        // 3: carry chain
        load(2'd0, 8'hFF);
        load(2'd1, 8'h01);
        issue("wrap", 3'b000, 1'b0, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0, 8'h00);
        chk_reg("wrap_r2", 2'd2, 8'h00);
        check("wrap_flags", {13'h0, flag_c, flag_cf, flag_z}, 16'h0007);
        load(2'd0, 8'h01);
        issue("adc", 3'b000, 1'b1, 2'd3, 2'd0, 2'd1, 1'b1, 1'b0, 2'd0, 8'h00);
        chk_reg("adc_r3", 2'd3, 8'h03);
        check("adc_flags", {13'h0, flag_c, flag_cf, flag_z}, 16'h0000);

        // Load on the accept edge is not seen by the captured operand
        in_valid = 1'b1; in_opcode = 3'b000; in_use_c = 1'b0;
        in_rd = 2'd2; in_rs1 = 2'd0; in_rs2 = 2'd1;
        ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'h10;
        tick();
        in_valid = 1'b0; ld_en = 1'b0;
        check("cap_alu_b", {8'h00, alu_b}, 16'h0001);
        tick();
        chk_reg("cap_r2", 2'd2, 8'h02);
        chk_reg("cap_r1", 2'd1, 8'h10);

        // 4: back-to-back handshake with in_valid held high
        in_valid = 1'b1; in_opcode = 3'b011; in_rd = 2'd3; in_rs1 = 2'd0; in_rs2 = 2'd1;
        for (int i = 0; i < 6; i++) begin
            check("hs_ready", {15'h0, in_ready}, (i % 2 == 0) ? 16'h0001 : 16'h0000);
            if (in_ready) accepts++;
            tick();
            check("hs_done", {15'h0, done}, (i % 2 == 1) ? 16'h0001 : 16'h0000);
        end
        in_valid = 1'b0;
        check("hs_accepts", 16'(accepts), 16'd3);
        chk_reg("hs_r3", 2'd3, 8'h11);

        // 5: load/writeback collisions on the closing edge
        issue("col_same", 3'b000, 1'b0, 2'd2, 2'd0, 2'd1, 1'b0, 1'b1, 2'd2, 8'h55);
        chk_reg("col_same_r2", 2'd2, 8'h11);
        issue("col_diff", 3'b000, 1'b0, 2'd2, 2'd0, 2'd1, 1'b0, 1'b1, 2'd3, 8'h55);
        chk_reg("col_diff_r3", 2'd3, 8'h55);
        chk_reg("col_diff_r2", 2'd2, 8'h11);

        // 6: reset during EXEC aborts the op
        in_valid = 1'b1; in_opcode = 3'b000; in_rd = 2'd2; in_rs1 = 2'd0; in_rs2 = 2'd1;
        tick();
        in_valid = 1'b0;
        check("mid_ready_exec", {15'h0, in_ready}, 16'h0000);
        rst_n = 1'b0;
        #2;
        check("mid_done_rst", {15'h0, done}, 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_done_after", {15'h0, done}, 16'h0000);
        check("mid_ready", {15'h0, in_ready}, 16'h0001);
        check("mid_flags", {13'h0, flag_c, flag_cf, flag_z}, 16'h0000);
        check("mid_alu_a", {8'h00, alu_a}, 16'h0000);
        chk_reg("mid_r0", 2'd0, 8'h00);
        chk_reg("mid_r2", 2'd2, 8'h00);
        chk_reg("mid_r3", 2'd3, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
